// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master side requests runs and divisors; the slave side reports the divided clock and status.
interface clk_div_prog_if #(
    parameter int DIV_W = 8
);
    logic             enable;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic             div_err;

    modport master (
        output enable, div_val, div_load,
        input  clk_out, tick, running, div_err
    );

    modport slave (
        input  enable, div_val, div_load,
        output clk_out, tick, running, div_err
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty integer clock divider (N = 2..2^DIV_W-1).
// Divisor changes and stops take effect only at period boundaries, so clk_out has no runt phases.
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    clk_div_prog_if.slave  bus
);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             run_q, run_d;
    logic             pos_q, pos_d;
    logic             neg_q, neg_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             load_ok;
    logic             boundary;

    always_comb begin
        cnt_d    = cnt_q;
        act_d    = act_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        run_d    = run_q;
        pos_d    = pos_q;
        tick_d   = 1'b0;
        load_ok  = bus.div_load && (bus.div_val >= TWO);
        err_d    = bus.div_load && (bus.div_val < TWO);
        boundary = run_q && (cnt_q == (act_q - ONE));

        if (!run_q) begin
            // Idle: every edge behaves like a boundary, loads land directly.
            cnt_d = '0;
            pos_d = 1'b0;
            if (pend_v_q) begin
                act_d    = pend_q;
                pend_v_d = 1'b0;
            end
            if (load_ok) begin
                act_d = bus.div_val;
            end
            if (bus.enable) begin
                run_d  = 1'b1;
                pos_d  = 1'b1;
                tick_d = 1'b1;
            end
        end else if (boundary) begin
            cnt_d = '0;
            if (pend_v_q) begin
                act_d    = pend_q;
                pend_v_d = 1'b0;
            end
            if (bus.enable) begin
                pos_d  = 1'b1;
                tick_d = 1'b1;
            end else begin
                run_d = 1'b0;
                pos_d = 1'b0;
            end
            // A load in the boundary cycle waits for the next boundary.
            if (load_ok) begin
                pend_d   = bus.div_val;
                pend_v_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + ONE;
            pos_d = (cnt_d < (act_q >> 1));
            if (load_ok) begin
                pend_d   = bus.div_val;
                pend_v_d = 1'b1;
            end
        end

        // Odd divisors stretch the high phase by half a cycle via the negedge copy.
        neg_d = act_q[0] & pos_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            act_q    <= DEF_DIV;
            pend_q   <= DEF_DIV;
            pend_v_q <= 1'b0;
            run_q    <= 1'b0;
            pos_q    <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            run_q    <= run_d;
            pos_q    <= pos_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign bus.clk_out = pos_q | neg_q;
    assign bus.tick    = tick_q;
    assign bus.running = run_q;
    assign bus.div_err = err_q;
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider with 50% duty cycle for both odd and even divisors.
- Generalises the fixed divide-by-3 posedge/negedge scheme to any divisor from 2 to 2^DIV_W-1.
- Adds glitch-free divisor changes at period boundaries, an enable with clean stop, and a period-start tick.
- Serves as the local clock-enable/strobe generator for the practice peripherals in the same clock domain.

Parameters:
- DIV_W, 8, width of the divisor and of the internal period counter.
- DEFAULT_DIV, 3, divisor loaded at reset; must be in the range 2..2^DIV_W-1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  run request; level-sensitive.
- div_val  input  DIV_W  requested divisor N.
- div_load  input  1  one-cycle strobe; captures div_val into the pending divisor.
- clk_out  output  1  divided clock, 50% duty.
- tick  output  1  registered one-cycle pulse in the first clk cycle of each clk_out period.
- running  output  1  high while periods are being generated.
- div_err  output  1  registered one-cycle pulse when div_load carries div_val < 2.

Behaviour:
- Reset (asynchronous, any time, including mid-period):
  - cnt = 0, active divisor = DEFAULT_DIV, no pending divisor.
  - pos_q, neg_q, clk_out, tick, running and div_err are all 0.
- Counter:
  - cnt counts 0..N-1 on posedge clk while running, where N is the active divisor.
  - The boundary cycle is the cycle with cnt == N-1; at the next posedge cnt wraps to 0.
- Even N:
  - pos_q (posedge flop) <= (next cnt < N/2).
  - clk_out = pos_q, so it is high for N/2 cycles.
- Odd N:
  - pos_q <= (next cnt < (N-1)/2).
  - neg_q samples pos_q on negedge clk.
  - clk_out = pos_q | neg_q, giving a high time of N/2 clk periods, rising on the posedge where cnt becomes 0.
- Mode is selected from the LSB of the active divisor. neg_q is forced to 0 in even mode.
- tick = 1 in exactly the cycles with cnt == 0 while running.
- Divisor load:
  - If div_load = 1 and div_val >= 2: pending <= div_val, pend_v <= 1. The last load before a boundary wins.
  - If div_load = 1 and div_val < 2: pending is unchanged; div_err pulses for one cycle.
  - At the boundary posedge: if pend_v = 1, active <= pending and pend_v <= 0.
  - A load in the boundary cycle itself is applied at the following boundary.
  - When not running, a valid load updates the active divisor directly on that edge.
- Start:
  - While enable = 1 and running = 0: at the next posedge, running <= 1 and cnt <= 0, so tick and the clk_out rise occur in that cycle.
- Stop:
  - enable = 0 while running: the current period completes.
  - At the boundary posedge: running <= 0, cnt holds 0, pos_q <= 0, and clk_out stays low. No runt pulse is produced.
  - If enable returns to 1 before the boundary, operation continues uninterrupted.
- Duty rule: clk_out never shows a high or low phase shorter than floor(N/2) clk periods of the outgoing or incoming divisor.

Test Plan:
- Reset release, enable = 1, default N = 3 -> clk_out period 3 clk with high time 1.5 clk; tick every 3 cycles; running = 1 one cycle after enable.
- Load N = 4 mid-period -> current 3-cycle period completes, then clk_out shows 2 high / 2 low; first tick of the new divisor lands exactly at the boundary.
- Load N = 7 then N = 5 before the same boundary, then load N = 9 in the boundary cycle -> one period of 5 (2.5 high), then periods of 9 (4.5 high).
- div_load with div_val = 0 and then 1 -> one-cycle div_err pulse for each; divisor and period unchanged.
- Drop enable at cnt = 1 with N = 6 -> period finishes (3 high, 3 low), then running = 0 and clk_out = 0 with no glitch; re-enable -> clk_out rises on the next posedge.
- Assert reset_n low while clk_out is high with N = 5 -> all outputs 0 asynchronously; after release and enable = 1, N = 3 is in effect.
